// File: rtl/avalon_reg_bank.sv
// Avalon-MM slave register bank: operand words, core-written result window,
// start/done handshake FSM with level interrupt. Reads have one cycle latency.
module avalon_reg_bank #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int RES_BASE  = 8,
  parameter int RES_WORDS = 4,
  parameter int START_IDX = 14,
  parameter int DONE_IDX  = 15
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           AVL_READ,
  input  logic                           AVL_WRITE,
  input  logic                           AVL_CS,
  input  logic [DATA_W/8-1:0]            AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]              AVL_ADDR,
  input  logic [DATA_W-1:0]              AVL_WRITEDATA,
  output logic [DATA_W-1:0]              AVL_READDATA,
  output logic                           CORE_START,
  output logic                           CORE_BUSY,
  input  logic                           CORE_DONE,
  input  logic                           CORE_WE,
  input  logic [$clog2(RES_WORDS)-1:0]   CORE_WADDR,
  input  logic [DATA_W-1:0]              CORE_WDATA,
  output logic [RES_BASE*DATA_W-1:0]     OPERANDS,
  output logic [DATA_W-1:0]              EXPORT_DATA,
  output logic                           IRQ
);

  localparam int BE_W = DATA_W / 8;
  localparam int RW_W = $clog2(RES_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_go;
  logic                r_irq_en;
  logic                r_done;
  logic                r_core_start;
  logic                r_core_busy;
  logic                r_irq;

  logic                w_wr;
  logic                w_rd;
  logic                w_addr_ok;
  logic                w_start_wr;
  logic [DATA_W-1:0]   w_rword;

  assign w_wr       = AVL_CS & AVL_WRITE;
  assign w_rd       = AVL_CS & AVL_READ & ~AVL_WRITE;
  assign w_addr_ok  = ({1'b0, AVL_ADDR} < (ADDR_W+1)'(NUM_REGS));
  assign w_start_wr = w_wr & w_addr_ok & (AVL_ADDR == ADDR_W'(START_IDX)) & AVL_BYTE_EN[0];

  // Only operand and result entries are ever written; every other entry stays 0
  // and therefore reads back as 0 through the plain array lookup.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned w = 0; w < NUM_REGS; w++) r_mem[w] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_REGS; w++) begin
        if (w < RES_BASE && w != START_IDX && w != DONE_IDX) begin
          if (w_wr && w_addr_ok && AVL_ADDR == ADDR_W'(w) && r_state != S_BUSY) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
              if (AVL_BYTE_EN[b]) r_mem[w][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
            end
          end
        end else if (w >= RES_BASE && w < RES_BASE + RES_WORDS) begin
          if (CORE_WE && CORE_WADDR == RW_W'(w - RES_BASE)) r_mem[w] <= CORE_WDATA;
        end
      end
    end
  end

  always_comb begin
    w_rword = '0;
    if (AVL_ADDR == ADDR_W'(START_IDX)) begin
      w_rword[2:0] = {r_state == S_BUSY, r_irq_en, r_go};
    end else if (AVL_ADDR == ADDR_W'(DONE_IDX)) begin
      w_rword[0] = r_done;
    end else if (w_addr_ok) begin
      w_rword = r_mem[AVL_ADDR];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_addr_ok ? w_rword : '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_go         <= 1'b0;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_core_start <= 1'b0;
      r_core_busy  <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_irq        <= r_done & r_irq_en;
      if (w_start_wr) begin
        r_go     <= AVL_WRITEDATA[0];
        r_irq_en <= AVL_WRITEDATA[1];
      end
      case (r_state)
        S_IDLE: begin
          if (w_start_wr && AVL_WRITEDATA[0]) begin
            r_core_start <= 1'b1;
            r_core_busy  <= 1'b1;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (CORE_DONE) begin
            r_done      <= 1'b1;
            r_core_busy <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_start_wr) begin
            r_done <= 1'b0;
            if (AVL_WRITEDATA[0]) begin
              r_core_start <= 1'b1;
              r_core_busy  <= 1'b1;
              r_state      <= S_BUSY;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < RES_BASE; g++) begin : g_ops
    assign OPERANDS[g*DATA_W +: DATA_W] = r_mem[g];
  end

  assign EXPORT_DATA  = r_mem[0];
  assign AVL_READDATA = r_rdata;
  assign CORE_START   = r_core_start;
  assign CORE_BUSY    = r_core_busy;
  assign IRQ          = r_irq;

endmodule
